// File: rtl/turfio_housekeeping.sv
// TURFIO housekeeping: delayed sync output, reset-settle indicator, heartbeat LED
// and rising-edge one-shots for the go command levels.
module turfio_housekeeping #(
  parameter int unsigned SYNC_TAP   = 15,
  parameter int unsigned LED_TCOUNT = 62500000,
  parameter int unsigned NGO        = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sync_req_i,
  output logic           sync_o,
  output logic           done_reset_o,
  output logic           led_o,
  input  logic [NGO-1:0] go_i,
  output logic [NGO-1:0] load_o
);

  localparam logic [4:0]  TAP_IDX  = 5'(SYNC_TAP);
  localparam logic [31:0] LED_LAST = 32'(LED_TCOUNT - 1);

  logic [31:0]    sdl_q, sdl_d;
  logic           sync_q, sync_d;
  logic [31:0]    rdl_q, rdl_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           led_q, led_d;
  logic [NGO-1:0] go_q, go_d;
  logic           tap;
  logic           tap_younger;

  assign tap = sdl_q[TAP_IDX];

  // The stage one step younger than the tap tells us whether the delayed
  // request is ending, so a held request fires SYNC_TAP+1 edges after release.
  generate
    if (SYNC_TAP == 0) begin : g_tap0
      assign tap_younger = sync_req_i;
    end else begin : g_tapn
      localparam logic [4:0] PREV_IDX = 5'(SYNC_TAP - 1);
      assign tap_younger = sdl_q[PREV_IDX];
    end
  endgenerate

  always_comb begin
    sdl_d  = {sdl_q[30:0], sync_req_i};
    sync_d = sync_q;
    if (sync_req_i) begin
      sync_d = 1'b0;
    end else if (tap && !tap_younger) begin
      sync_d = 1'b1;
    end

    rdl_d = {rdl_q[30:0], 1'b1};

    cnt_d = cnt_q + 32'd1;
    led_d = led_q;
    if (cnt_q == LED_LAST) begin
      cnt_d = '0;
      led_d = ~led_q;
    end

    go_d = go_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdl_q  <= '0;
      sync_q <= 1'b0;
      rdl_q  <= '0;
      cnt_q  <= '0;
      led_q  <= 1'b0;
      go_q   <= '1;
    end else begin
      sdl_q  <= sdl_d;
      sync_q <= sync_d;
      rdl_q  <= rdl_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      go_q   <= go_d;
    end
  end

  // go_q resets to all ones so a level already high at release is not a new edge.
  assign sync_o       = sync_q;
  assign done_reset_o = rdl_q[31];
  assign led_o        = led_q;
  assign load_o       = go_i & ~go_q;

endmodule

// File: tb/tb_turfio_housekeeping.sv
// Directed bench for turfio_housekeeping with an event-level reference model
// checked every cycle, plus literal checks at hand-computed edges.
module tb_turfio_housekeeping;

  localparam int TAP  = 15;
  localparam int LCNT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_req_i;
  logic       sync_o;
  logic       done_reset_o;
  logic       led_o;
  logic [1:0] go_i;
  logic [1:0] load_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  logic       m_valid    = 1'b0;
  logic       m_sync     = 1'b0;
  logic       m_prev_req = 1'b0;
  logic [1:0] m_prev_go  = 2'b11;
  int         m_edge     = 0;
  int         m_n        = 0;
  int         fire_q[$];

  turfio_housekeeping #(
    .SYNC_TAP  (TAP),
    .LED_TCOUNT(LCNT),
    .NGO       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sync_req_i  (sync_req_i),
    .sync_o      (sync_o),
    .done_reset_o(done_reset_o),
    .led_o       (led_o),
    .go_i        (go_i),
    .load_o      (load_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: sync_o fires SYNC_TAP+1 edges after the last edge of each request run;
  // done/led derive from the count of non-reset edges since reset.
  initial begin
    forever begin
      logic fire_now;
      @(posedge clk);
      m_edge++;
      if (rst) begin
        m_valid    = 1'b1;
        m_sync     = 1'b0;
        m_n        = 0;
        m_prev_req = 1'b0;
        m_prev_go  = 2'b11;
        fire_q.delete();
      end else begin
        m_n++;
        if (!sync_req_i && m_prev_req) fire_q.push_back(m_edge + TAP);
        fire_now = 1'b0;
        while (fire_q.size() > 0 && fire_q[0] <= m_edge) begin
          if (fire_q[0] == m_edge) fire_now = 1'b1;
          void'(fire_q.pop_front());
        end
        if (sync_req_i) m_sync = 1'b0;
        else if (fire_now) m_sync = 1'b1;
        m_prev_req = sync_req_i;
        m_prev_go  = go_i;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cyc_sync", sync_o, m_sync);
        check("cyc_done", done_reset_o, m_n >= 32);
        check("cyc_led", led_o, ((m_n / LCNT) % 2) != 0);
        check("cyc_load", load_o, go_i & ~m_prev_go);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst = 1'b1;
    sync_req_i = 1'b0;
    go_i = 2'b11;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    check("rst_sync", sync_o, 0);
    check("rst_done", done_reset_o, 0);
    check("rst_led", led_o, 0);
    check("rst_load", load_o, 0);
    rst = 1'b0;

    run_to(1);
    check("go_held_release_load", load_o, 0);
    check("done_e1", done_reset_o, 0);
    run_to(2);
    go_i = 2'b00;
    run_to(3);
    check("led_e3", led_o, 0);
    run_to(4);
    check("led_e4", led_o, 1);
    go_i = 2'b01;
    #1 check("load_ch0", load_o, 2'b01);
    run_to(5);
    check("load_ch0_once", load_o, 0);
    run_to(8);
    check("led_e8", led_o, 0);
    go_i = 2'b11;
    #1 check("load_ch1", load_o, 2'b10);
    run_to(9);
    check("load_ch1_once", load_o, 0);
    sync_req_i = 1'b1;
    run_to(10);
    sync_req_i = 1'b0;
    run_to(25);
    check("sync_e25", sync_o, 0);
    run_to(26);
    check("sync_e26", sync_o, 1);
    run_to(31);
    check("done_e31", done_reset_o, 0);
    run_to(32);
    check("done_e32", done_reset_o, 1);
    run_to(44);
    check("sync_hold_e44", sync_o, 1);
    sync_req_i = 1'b1;
    run_to(45);
    sync_req_i = 1'b0;
    check("sync_clr_e45", sync_o, 0);

    run_to(49);
    rst = 1'b1;
    run_to(50);
    rst = 1'b0;
    check("midrst_done", done_reset_o, 0);
    check("midrst_led", led_o, 0);
    check("midrst_sync", sync_o, 0);
    run_to(51);
    check("go_held_midrst_load", load_o, 0);
    run_to(53);
    check("led_e53", led_o, 0);
    run_to(54);
    check("led_e54", led_o, 1);
    run_to(61);
    check("sync_discarded_e61", sync_o, 0);
    run_to(62);
    go_i = 2'b00;
    run_to(64);
    go_i = 2'b10;
    #1 check("load_ch1_again", load_o, 2'b10);
    run_to(65);
    check("load_ch1_again_once", load_o, 0);
    run_to(81);
    check("done_e81", done_reset_o, 0);
    run_to(82);
    check("done_e82", done_reset_o, 1);

    run_to(89);
    sync_req_i = 1'b1;
    run_to(90);
    sync_req_i = 1'b0;
    run_to(105);
    check("sync_e105", sync_o, 0);
    run_to(106);
    check("sync_e106", sync_o, 1);
    run_to(109);
    sync_req_i = 1'b1;
    run_to(110);
    check("sync_held_first_e110", sync_o, 0);
    run_to(112);
    sync_req_i = 1'b0;
    run_to(127);
    check("sync_held_e127", sync_o, 0);
    run_to(128);
    check("sync_held_e128", sync_o, 1);

    run_to(139);
    sync_req_i = 1'b1;
    run_to(159);
    sync_req_i = 1'b0;
    check("sync_long_e159", sync_o, 0);
    run_to(174);
    check("sync_long_e174", sync_o, 0);
    run_to(175);
    check("sync_long_e175", sync_o, 1);
    run_to(180);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
